// File: rtl/decmc_pkg.sv
// Shared opcode encoding, command-word field offsets and saturating arithmetic
// for the multi-channel command decoder.
package decmc_pkg;

   localparam int OPC_W = 4;
   localparam int SAT_W = 32;

   // Field positions counted down from the MSB of the command word.
   localparam int PAR_OFS = 1;
   localparam int OPC_OFS = 2;
   localparam int CH_OFS  = OPC_OFS + OPC_W;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP     = 4'd0,
      OP_ON      = 4'd1,
      OP_OFF     = 4'd2,
      OP_INC     = 4'd3,
      OP_DEC     = 4'd4,
      OP_SET     = 4'd5,
      OP_SEND    = 4'd6,
      OP_RECEIVE = 4'd7
   } opcode_e;

   function automatic logic [SAT_W-1:0] saturate_add(input logic [SAT_W-1:0] a,
                                                      input logic [SAT_W-1:0] b,
                                                      input int aw);
      logic [SAT_W:0] sum;
      logic [SAT_W:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (SAT_W+1)'((64'd1 << aw) - 64'd1);
      return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
   endfunction

   function automatic logic [SAT_W-1:0] saturate_sub(input logic [SAT_W-1:0] a,
                                                      input logic [SAT_W-1:0] b,
                                                      input int aw);
      logic [SAT_W-1:0] mask;
      mask = SAT_W'((64'd1 << aw) - 64'd1);
      return (b > a) ? '0 : ((a - b) & mask);
   endfunction

endpackage

// File: rtl/dec_channel.sv
// One decoder channel: enable flag plus saturating amount register,
// updated only when the top level asserts hit for an accepted, error-free word.
module dec_channel
   import decmc_pkg::*;
#(
   parameter int AMOUNT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  opcode_e                 op,
   input  logic [AMOUNT_WIDTH-1:0] amt,
   input  logic                    hit,
   output logic                    en,
   output logic [AMOUNT_WIDTH-1:0] amount,
   output logic [AMOUNT_WIDTH-1:0] next_amount
);

   always_comb begin
      next_amount = amount;
      case (op)
         OP_INC:  next_amount = AMOUNT_WIDTH'(saturate_add(SAT_W'(amount), SAT_W'(amt), AMOUNT_WIDTH));
         OP_DEC:  next_amount = AMOUNT_WIDTH'(saturate_sub(SAT_W'(amount), SAT_W'(amt), AMOUNT_WIDTH));
         OP_SET:  next_amount = amt;
         default: next_amount = amount;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en     <= 1'b0;
         amount <= '0;
      end else if (hit) begin
         amount <= next_amount;
         if (op == OP_ON)
            en <= 1'b1;
         else if (op == OP_OFF)
            en <= 1'b0;
      end
   end

endmodule

// File: rtl/cmd_decoder_mc.sv
// Multi-channel command decoder: field extraction, legality checks, one-hot
// decode and a single back-pressurable result register. DEC_PARITY_EN adds an even-parity check.
module cmd_decoder_mc
   import decmc_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int AMOUNT_WIDTH = 8,
   parameter int NUM_CH       = 4,
   parameter int CH_W         = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   received_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    on,
   output logic                    off,
   output logic                    increase,
   output logic                    decrease,
   output logic                    send,
   output logic                    receive,
   output logic [CH_W-1:0]         out_ch,
   output logic [AMOUNT_WIDTH-1:0] amount,
   output logic                    err,
   output logic [NUM_CH-1:0]       ch_on
);

   logic [OPC_W-1:0]        opc;
   logic [CH_W-1:0]         ch;
   logic [AMOUNT_WIDTH-1:0] amt;
   logic                    accept;
   logic                    ch_ok;
   logic                    needs_en;
   logic                    err_c;
   logic [5:0]              flags_c;
   logic                    sel_en;
   logic [AMOUNT_WIDTH-1:0] sel_amt;
   logic [AMOUNT_WIDTH-1:0] sel_next;
   logic [NUM_CH-1:0]       ch_en;
   logic [AMOUNT_WIDTH-1:0] ch_amt  [NUM_CH];
   logic [AMOUNT_WIDTH-1:0] ch_next [NUM_CH];
   logic                    unused_bits;

   assign opc = received_data[DATA_WIDTH-OPC_OFS -: OPC_W];
   assign ch  = received_data[DATA_WIDTH-CH_OFS -: CH_W];
   assign amt = received_data[AMOUNT_WIDTH-1:0];

   // Bits between the channel and amount fields carry no meaning.
   assign unused_bits = ^received_data;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign ch_on    = ch_en;

   assign ch_ok    = int'(ch) < NUM_CH;
   assign needs_en = (opc == OP_INC) || (opc == OP_DEC) || (opc == OP_SET) ||
                     (opc == OP_SEND) || (opc == OP_RECEIVE);

   always_comb begin
      sel_en   = 1'b0;
      sel_amt  = '0;
      sel_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch == CH_W'(i)) begin
            sel_en   = ch_en[i];
            sel_amt  = ch_amt[i];
            sel_next = ch_next[i];
         end
      end
   end

   always_comb begin
      err_c = opc[OPC_W-1] || !ch_ok || (needs_en && !sel_en);
`ifdef DEC_PARITY_EN
      if (^received_data)
         err_c = 1'b1;
`endif
   end

   always_comb begin
      flags_c = '0;
      if (!err_c) begin
         case (opc)
            OP_ON:      flags_c = 6'b100000;
            OP_OFF:     flags_c = 6'b010000;
            OP_INC:     flags_c = 6'b001000;
            OP_DEC:     flags_c = 6'b000100;
            OP_SEND:    flags_c = 6'b000010;
            OP_RECEIVE: flags_c = 6'b000001;
            default:    flags_c = '0;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dec_channel #(
         .AMOUNT_WIDTH (AMOUNT_WIDTH)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .op          (opcode_e'(opc)),
         .amt         (amt),
         .hit         (accept && !err_c && (ch == CH_W'(g))),
         .en          (ch_en[g]),
         .amount      (ch_amt[g]),
         .next_amount (ch_next[g])
      );
   end

   // Fields stay at their last value after the result is consumed; only out_valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         {on, off, increase, decrease, send, receive} <= '0;
         out_ch    <= '0;
         amount    <= '0;
         err       <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         {on, off, increase, decrease, send, receive} <= flags_c;
         out_ch    <= ch;
         amount    <= err_c ? sel_amt : sel_next;
         err       <= err_c;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cmd_decoder_mc.sv
// Bench for cmd_decoder_mc: directed vector table, back-pressure/reset sequences
// and a randomized cycle-level run against an abstract channel model.
module tb_cmd_decoder_mc;

   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int NCH = 4;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [DW-1:0] received_data = '0;
   logic          in_ready, out_valid, on, off, increase, decrease, send, receive, err;
   logic [CW-1:0] out_ch;
   logic [AW-1:0] amount;
   logic [NCH-1:0] ch_on;

   cmd_decoder_mc #(
      .DATA_WIDTH (DW), .AMOUNT_WIDTH (AW), .NUM_CH (NCH), .CH_W (CW)
   ) dut (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
      .received_data (received_data), .out_valid (out_valid), .out_ready (out_ready),
      .on (on), .off (off), .increase (increase), .decrease (decrease),
      .send (send), .receive (receive), .out_ch (out_ch), .amount (amount),
      .err (err), .ch_on (ch_on)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       err;
      logic [5:0] flags;
      logic [3:0] ch;
      logic [7:0] amount;
   } res_t;

   typedef struct {
      int         op;
      int         ch;
      int         amt;
      logic       err;
      logic [5:0] flags;
      logic [7:0] amount;
      logic [3:0] chon;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_en  [16];
   int   m_amt [16];
   vec_t tbl   [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_word(input int op, input int ch, input int amt);
      logic [31:0] w;
      w = (32'(op & 15) << 27) | (32'(ch & 15) << 23) | 32'(amt & 255);
      w[31] = ^w[30:0];
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_en[i]  = 0;
         m_amt[i] = 0;
      end
   endtask

   function automatic logic [3:0] model_chon();
      logic [3:0] v;
      for (int i = 0; i < NCH; i++) v[i] = (m_en[i] != 0);
      return v;
   endfunction

   task automatic model_step(input logic [31:0] w, output res_t r);
      int op, ch, amt;
      bit bad;
      op  = int'(w[30:27]);
      ch  = int'(w[26:23]);
      amt = int'(w[7:0]);
      r.ch     = w[26:23];
      r.err    = 1'b0;
      r.flags  = '0;
      r.amount = (ch < NCH) ? 8'(m_amt[ch]) : 8'd0;
      bad = (op > 7) || (ch >= NCH) || (op >= 3 && m_en[ch] == 0);
`ifdef DEC_PARITY_EN
      if (^w) bad = 1'b1;
`endif
      if (bad) begin
         r.err = 1'b1;
      end else begin
         case (op)
            1: m_en[ch] = 1;
            2: m_en[ch] = 0;
            3: m_amt[ch] = (m_amt[ch] + amt > 255) ? 255 : m_amt[ch] + amt;
            4: m_amt[ch] = (amt > m_amt[ch]) ? 0 : m_amt[ch] - amt;
            5: m_amt[ch] = amt;
            default: ;
         endcase
         case (op)
            1: r.flags = 6'b100000;
            2: r.flags = 6'b010000;
            3: r.flags = 6'b001000;
            4: r.flags = 6'b000100;
            6: r.flags = 6'b000010;
            7: r.flags = 6'b000001;
            default: r.flags = '0;
         endcase
         r.amount = 8'(m_amt[ch]);
      end
   endtask

   task automatic chk_result(input string tag, input res_t e);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".err"}, 32'(err), 32'(e.err));
      chk({tag, ".flags"}, 32'({on, off, increase, decrease, send, receive}), 32'(e.flags));
      chk({tag, ".out_ch"}, 32'(out_ch), 32'(e.ch));
      chk({tag, ".amount"}, 32'(amount), 32'(e.amount));
   endtask

   initial begin
      res_t        e;
      logic [31:0] w;
      bit          exp_valid;
      bit          acc;

      tbl[0]  = '{1, 2, 8'h00, 1'b0, 6'b100000, 8'h00, 4'b0100};
      tbl[1]  = '{5, 2, 8'h40, 1'b0, 6'b000000, 8'h40, 4'b0100};
      tbl[2]  = '{3, 2, 8'hF0, 1'b0, 6'b001000, 8'hFF, 4'b0100};
      tbl[3]  = '{3, 2, 8'h01, 1'b0, 6'b001000, 8'hFF, 4'b0100};
      tbl[4]  = '{5, 2, 8'h05, 1'b0, 6'b000000, 8'h05, 4'b0100};
      tbl[5]  = '{4, 2, 8'h10, 1'b0, 6'b000100, 8'h00, 4'b0100};
      tbl[6]  = '{4, 2, 8'h01, 1'b0, 6'b000100, 8'h00, 4'b0100};
      tbl[7]  = '{1, 2, 8'h00, 1'b0, 6'b100000, 8'h00, 4'b0100};
      tbl[8]  = '{5, 2, 8'h33, 1'b0, 6'b000000, 8'h33, 4'b0100};
      tbl[9]  = '{2, 2, 8'h00, 1'b0, 6'b010000, 8'h33, 4'b0000};
      tbl[10] = '{3, 2, 8'h01, 1'b1, 6'b000000, 8'h33, 4'b0000};
      tbl[11] = '{11, 0, 8'h00, 1'b1, 6'b000000, 8'h00, 4'b0000};
      tbl[12] = '{1, 7, 8'h00, 1'b1, 6'b000000, 8'h00, 4'b0000};
      tbl[13] = '{0, 1, 8'h00, 1'b0, 6'b000000, 8'h00, 4'b0000};
      tbl[14] = '{6, 1, 8'h00, 1'b1, 6'b000000, 8'h00, 4'b0000};
      tbl[15] = '{1, 1, 8'h00, 1'b0, 6'b100000, 8'h00, 4'b0010};
      tbl[16] = '{6, 1, 8'h00, 1'b0, 6'b000010, 8'h00, 4'b0010};
      tbl[17] = '{7, 1, 8'h77, 1'b0, 6'b000001, 8'h00, 4'b0010};
      tbl[18] = '{0, 9, 8'h00, 1'b1, 6'b000000, 8'h00, 4'b0010};
      tbl[19] = '{3, 1, 8'h10, 1'b0, 6'b001000, 8'h10, 4'b0010};
      tbl[20] = '{2, 2, 8'h00, 1'b0, 6'b010000, 8'h33, 4'b0010};

      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.flags", 32'({on, off, increase, decrease, send, receive}), 32'd0);
      chk("rst.out_ch", 32'(out_ch), 32'd0);
      chk("rst.amount", 32'(amount), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      chk("rst.ch_on", 32'(ch_on), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle.out_valid", 32'(out_valid), 32'd0);

      for (int i = 0; i < 21; i++) begin
         w = mk_word(tbl[i].op, tbl[i].ch, tbl[i].amt);
         in_valid = 1'b1;
         received_data = w;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         model_step(w, e);
         e.err    = tbl[i].err;
         e.flags  = tbl[i].flags;
         e.amount = tbl[i].amount;
         chk_result($sformatf("vec%0d", i), e);
         chk($sformatf("vec%0d.ch_on", i), 32'(ch_on), 32'(tbl[i].chon));
      end

      // ON ch0 with odd parity
      w = mk_word(1, 0, 0);
      w[31] = ~w[31];
      in_valid = 1'b1;
      received_data = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_step(w, e);
`ifdef DEC_PARITY_EN
      chk("par.err", 32'(err), 32'd1);
      chk("par.on", 32'(on), 32'd0);
      chk("par.ch_on", 32'(ch_on), 32'b0010);
`else
      chk("par.err", 32'(err), 32'd0);
      chk("par.on", 32'(on), 32'd1);
      chk("par.ch_on", 32'(ch_on), 32'b0011);
`endif

      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      w = mk_word(5, 1, 8'h22);
      received_data = w;
      @(posedge clk);
      #1;
      model_step(w, e);
      chk_result("bp.first", e);
      w = mk_word(3, 1, 1);
      received_data = w;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("bp.hold%0d.in_ready", k), 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         chk_result($sformatf("bp.hold%0d", k), e);
         chk($sformatf("bp.hold%0d.amount", k), 32'(amount), 32'h22);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release.in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         model_step(w, e);
         chk_result($sformatf("b2b%0d", k), e);
         chk($sformatf("b2b%0d.amount", k), 32'(amount), 32'(8'h23 + k));
         w = mk_word(3, 1, 1);
         received_data = w;
      end
      in_valid = 1'b0;

      // reset while a result is pending and back-pressured
      out_ready = 1'b0;
      in_valid = 1'b1;
      received_data = mk_word(0, 1, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("pend.out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", 32'(out_valid), 32'd0);
      chk("midrst.ch_on", 32'(ch_on), 32'd0);
      chk("midrst.amount", 32'(amount), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      exp_valid = 1'b0;
      e = '{1'b0, 6'd0, 4'd0, 8'd0};

      for (int n = 0; n < 600; n++) begin
         int r, op, ch;
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         r  = int'($urandom % 16);
         op = (r < 12) ? (r % 8) : int'($urandom % 16);
         ch = (($urandom % 8) == 0) ? int'($urandom % 16) : int'($urandom % NCH);
         w = mk_word(op, ch, int'($urandom % 256));
         w[22:8] = 15'($urandom);
         w[31] = ^w[30:0];
         if (($urandom % 10) == 0) w[31] = ~w[31];
         received_data = w;
         #1;
         chk("rnd.in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
         acc = in_valid && (!exp_valid || out_ready);
         @(posedge clk);
         #1;
         if (acc) begin
            model_step(w, e);
            exp_valid = 1'b1;
         end else if (out_ready) begin
            exp_valid = 1'b0;
         end
         if (exp_valid)
            chk_result($sformatf("rnd%0d", n), e);
         else
            chk($sformatf("rnd%0d.out_valid", n), 32'(out_valid), 32'd0);
         chk($sformatf("rnd%0d.ch_on", n), 32'(ch_on), 32'(model_chon()));
      end
      in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
